// File: rtl/nand_share_arbiter_pkg.sv
// Shared types and helpers for the shared NAND-cell arbiter family.
// Latency: none (types and constant/combinational functions only).
// Backpressure: not applicable.
package nand_share_pkg;

  // Top-level sequencing of one shared-cell operation.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Largest requester count the round-robin helper can search.
  localparam int RR_MAX_REQ = 32;

  // Default settle time and the matching settle-counter width.
  localparam int SETTLE_CYCLES_DEF = 2;
  localparam int SETTLE_CNT_W      = $clog2(SETTLE_CYCLES_DEF + 1);

  // Counter width for an arbitrary settle time. The counter is loaded with
  // settle-1, so the width is a little generous.
  function automatic int settle_cnt_w(input int settle);
    return (settle < 1) ? 1 : $clog2(settle + 1);
  endfunction

  // Round-robin winner: first set bit of valid at or above ptr, wrapping at num.
  // Returns -1 when no bit below num is set. The loop walks offsets downward so
  // the smallest offset from ptr is written last and wins.
  function automatic int rr_pick(input logic [RR_MAX_REQ-1:0] valid,
                                 input int num,
                                 input int ptr);
    int idx;
    int win;
    win = -1;
    for (int k = RR_MAX_REQ - 1; k >= 0; k--) begin
      if (k < num) begin
        idx = ptr + k;
        if (idx >= num) idx = idx - num;
        if (valid[idx]) win = idx;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/nand_share_arbiter_rr.sv
// One-hot round-robin picker: first requester at or above ptr, with wrap.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the grant is consumed.
module rr_arbiter
  import nand_share_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic [N-1:0]   o_gnt,
  output logic [IDW-1:0] o_idx,
  output logic           o_any
);

  int w_pick;

  // Search from the pointer upward and convert the winner to index + one-hot.
  always_comb begin
    w_pick = rr_pick(RR_MAX_REQ'(i_req), N, int'(i_ptr));
    o_any  = (w_pick >= 0);
    o_idx  = '0;
    o_gnt  = '0;
    if (o_any) begin
      o_idx        = w_pick[IDW-1:0];
      o_gnt[o_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/nand_share_arbiter.sv
// Time-shares one NAND cell between NUM_REQ requesters, round-robin order.
// Latency: grant in cycle T gives rsp_valid from T+SETTLE_CYCLES+1.
// Backpressure: result held until rsp_ready; no new grant until back in IDLE.
module nand_share_arbiter
  import nand_share_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int ID_W          = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ-1:0] req_a,
  input  logic [NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0] req_ready,
  output logic               cell_a,
  output logic               cell_b,
  input  logic               cell_y,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic               rsp_y,
  output logic               busy
);

  localparam int                CNT_W    = settle_cnt_w(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ID_W-1:0]   LAST_ID  = ID_W'(NUM_REQ - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ID_W-1:0]   r_ptr;
  logic              r_cell_a;
  logic              r_cell_b;
  logic              r_rsp_valid;
  logic [ID_W-1:0]   r_rsp_id;
  logic              r_rsp_y;

  logic [NUM_REQ-1:0] w_gnt;
  logic [ID_W-1:0]    w_idx;
  logic               w_any;

  rr_arbiter #(
    .N   (NUM_REQ),
    .IDW (ID_W)
  ) u_rr (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // A grant is only offered while idle, so req_ready doubles as the accept.
  assign req_ready = (r_state == IDLE) ? w_gnt : '0;
  assign busy      = (r_state != IDLE);
  assign cell_a    = r_cell_a;
  assign cell_b    = r_cell_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_y     = r_rsp_y;

  // Operation sequencer: capture operands, hold them while the cell settles,
  // sample the cell once at the end, then hold the result until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_cell_a    <= 1'b0;
      r_cell_b    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_y     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_cell_a <= req_a[w_idx];
            r_cell_b <= req_b[w_idx];
            r_rsp_id <= w_idx;
            r_cnt    <= CNT_LOAD;
            r_ptr    <= (w_idx == LAST_ID) ? '0 : w_idx + 1'b1;
            r_state  <= SETTLE;
          end
        end
        SETTLE: begin
          // cell_y is only looked at here, in the final settle cycle.
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_rsp_y     <= cell_y;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          // Cell inputs deliberately keep their last value here.
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nand_share_arbiter.sv
// Directed bench for the shared NAND-cell arbiter with a behavioural NAND cell.
// Latency: checks grant-to-response timing and round-robin grant spacing.
// Backpressure: exercises a stalled response channel and reset during settle.
module tb_nand_share_arbiter;

  localparam int NREQ   = 4;
  localparam int SETTLE = 2;

  logic            clk;
  logic            rst_n;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_a;
  logic [NREQ-1:0] req_b;
  logic [NREQ-1:0] req_ready;
  logic            cell_a;
  logic            cell_b;
  logic            cell_y;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic            rsp_y;
  logic            busy;

  int n_chk  = 0;
  int n_fail = 0;

  nand_share_arbiter #(
    .NUM_REQ       (NREQ),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .cell_a    (cell_a),
    .cell_b    (cell_b),
    .cell_y    (cell_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .busy      (busy)
  );

  // Behavioural stand-in for the shared NAND cell.
  assign cell_y = ~(cell_a & cell_b);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation from requester idx with rsp_ready high; ends in IDLE.
  task automatic do_op(input string tag, input int idx, input logic a, input logic b,
                       input logic ey);
    int n;
    req_valid = NREQ'(1 << idx);
    req_a     = a ? NREQ'(1 << idx) : '0;
    req_b     = b ? NREQ'(1 << idx) : '0;
    #1;
    check({tag, "_gnt"}, req_ready, 1 << idx);
    tick();
    req_valid = '0;
    n = 0;
    while (!rsp_valid && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n, SETTLE);
    check({tag, "_id"}, rsp_id, idx);
    check({tag, "_y"}, rsp_y, ey);
    tick();
  endtask

  logic [3:0] y_tab;
  int k_g;
  int k_r;

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    #3;
    check("rst_ready", req_ready, 0);
    check("rst_cell_a", cell_a, 0);
    check("rst_cell_b", cell_b, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_y", rsp_y, 0);
    check("rst_busy", busy, 0);
    #9 rst_n = 1'b1;
    tick();

    // Single request from requester 0 with a=b=1.
    req_valid = 4'b0001;
    req_a     = 4'b0001;
    req_b     = 4'b0001;
    #1;
    check("t1_gnt", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    #1;
    check("t1_cell_a", cell_a, 1);
    check("t1_cell_b", cell_b, 1);
    check("t1_busy", busy, 1);
    check("t1_ready_settle", req_ready, 0);
    tick();
    check("t1_valid_t2", rsp_valid, 0);
    tick();
    check("t1_valid_t3", rsp_valid, 1);
    check("t1_id", rsp_id, 0);
    check("t1_y", rsp_y, 0);
    tick();
    check("t1_valid_t4", rsp_valid, 0);
    check("t1_busy_t4", busy, 0);

    // Reset while requester 1 is settling; pointer was 1.
    req_valid = 4'b0010;
    req_a     = 4'b0010;
    req_b     = 4'b0010;
    #1;
    check("rm_gnt", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    #1;
    check("rm_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rm_valid", rsp_valid, 0);
    check("rm_busy", busy, 0);
    check("rm_cell_a", cell_a, 0);
    check("rm_cell_b", cell_b, 0);
    #2 rst_n = 1'b1;
    tick();

    // All requesters held: grants 0,1,2,3,0 spaced four cycles apart.
    y_tab     = 4'b1110;
    req_valid = 4'b1111;
    req_a     = 4'b0101;
    req_b     = 4'b0011;
    rsp_ready = 1'b1;
    #1;
    k_g = 0;
    k_r = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (req_ready != '0) begin
        if (k_g < 5) begin
          check("rr_gnt", req_ready, 1 << (k_g % 4));
          check("rr_cyc", cyc, 4 * k_g);
        end
        k_g++;
      end
      if (rsp_valid) begin
        if (k_r < 5) begin
          check("rr_id", rsp_id, k_r % 4);
          check("rr_y", rsp_y, y_tab[k_r % 4]);
        end
        k_r++;
      end
      if (cyc == 19) req_valid = '0;
      tick();
    end
    check("rr_ngnt", k_g, 5);
    check("rr_nrsp", k_r, 5);

    // NAND truth table through requester 2, back to back.
    do_op("tt00", 2, 1'b0, 1'b0, 1'b1);
    do_op("tt01", 2, 1'b0, 1'b1, 1'b1);
    do_op("tt10", 2, 1'b1, 1'b0, 1'b1);
    do_op("tt11", 2, 1'b1, 1'b1, 1'b0);

    // Stalled response channel; pointer is 3 so requester 1 wins alone.
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    req_a     = 4'b0010;
    req_b     = 4'b0000;
    #1;
    check("bp_gnt", req_ready, 4'b0010);
    tick();
    req_valid = 4'b1111;
    #1;
    check("bp_ready_settle", req_ready, 0);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", rsp_valid, 1);
      check("bp_id", rsp_id, 1);
      check("bp_y", rsp_y, 1);
      check("bp_busy", busy, 1);
      check("bp_ready", req_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_hold_last", rsp_valid, 1);
    tick();
    check("bp_valid_done", rsp_valid, 0);
    check("bp_next_gnt", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    tick();
    tick();
    check("pw_id2", rsp_id, 2);
    tick();

    // Pointer now 3: requesters 0 and 2 -> wrap to 0, then 2.
    req_valid = 4'b0101;
    #1;
    check("pw_gnt_wrap", req_ready, 4'b0001);
    tick();
    tick();
    tick();
    check("pw_id0", rsp_id, 0);
    tick();
    check("pw_gnt_next", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();
    // Idle cycles must not move the pointer (stays 3 after grant to 2).
    tick();
    tick();
    req_valid = 4'b1111;
    #1;
    check("idle_ptr_gnt", req_ready, 4'b1000);
    req_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
